// File: rtl/jt51_regwr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jt51_regwr                                                      |
// | Purpose  : CPU write front-end for the jt51 register file: captures bus    |
// |            writes, decodes the YM2151 map into slot-long update strobes.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module jt51_regwr #(
  parameter int BUSY_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       busy,
  output logic       ovr,
  output logic [7:0] d_out,
  output logic [1:0] op,
  output logic [2:0] ch,
  output logic       up_rl,
  output logic       up_kc,
  output logic       up_kf,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks,
  output logic       up_amsen,
  output logic       up_dt2,
  output logic       up_d1l,
  output logic       up_keyon,
  output logic       glb_wr,
  output logic [7:0] glb_addr
);

  localparam int CW = $clog2(BUSY_CYC);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_HOLD = 2'd1;
  localparam logic [1:0] C_TAIL = 2'd2;

  localparam logic [CW-1:0] C_HOLD_LAST = CW'(31);
  localparam logic [CW-1:0] C_BUSY_LAST = CW'(BUSY_CYC - 1);

  localparam int C_KEYON = 0;
  localparam int C_RL    = 1;
  localparam int C_KC    = 2;
  localparam int C_KF    = 3;
  localparam int C_PMS   = 4;
  localparam int C_DT1   = 5;
  localparam int C_TL    = 6;
  localparam int C_KS    = 7;
  localparam int C_AMSEN = 8;
  localparam int C_DT2   = 9;
  localparam int C_D1L   = 10;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrs_q;
  logic          pend_q;
  logic          ovr_req_q;
  logic          ovr_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic [7:0]    d_out_q;
  logic [1:0]    op_q;
  logic [2:0]    ch_q;
  logic [10:0]   strb_q;
  logic          busy_q;
  logic          glb_wr_q;
  logic [7:0]    glb_addr_q;

  logic          w_wrs;
  logic          w_fall;
  logic          w_accept;
  logic          w_drop;
  logic          w_load;
  logic          w_cnt_inc;
  logic          w_hold_end;
  logic          w_tail_end;
  logic [10:0]   w_strb_dec;
  logic          w_glb;
  logic [1:0]    w_op;

  // Bus capture runs on every clk so a CPU write is never missed while clk_en is low.
  assign w_wrs    = wr_n | cs_n;
  assign w_fall   = wrs_q & ~w_wrs;
  assign w_accept = w_fall & a0 & (state_q == C_IDLE) & ~pend_q;
  assign w_drop   = w_fall & a0 & ~((state_q == C_IDLE) & ~pend_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrs_q     <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      pend_q    <= 1'b0;
      ovr_req_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      wrs_q <= w_wrs;
      if (w_fall && !a0) addr_q <= din;
      if (w_load) pend_q <= 1'b0;
      if (w_accept) begin
        pend_q <= 1'b1;
        data_q <= din;
      end
      if (clk_en) begin
        ovr_q     <= ovr_req_q;
        ovr_req_q <= 1'b0;
      end
      if (w_drop) ovr_req_q <= 1'b1;
    end
  end

  always_comb begin
    w_strb_dec = '0;
    w_glb      = 1'b0;
    if (addr_q == 8'h08) begin
      w_strb_dec[C_KEYON] = 1'b1;
    end else if (addr_q < 8'h20) begin
      w_glb = 1'b1;
    end else if (addr_q < 8'h40) begin
      case (addr_q[4:3])
        2'd0:    w_strb_dec[C_RL]  = 1'b1;
        2'd1:    w_strb_dec[C_KC]  = 1'b1;
        2'd2:    w_strb_dec[C_KF]  = 1'b1;
        default: w_strb_dec[C_PMS] = 1'b1;
      endcase
    end else begin
      case (addr_q[7:5])
        3'd2:    w_strb_dec[C_DT1]   = 1'b1;
        3'd3:    w_strb_dec[C_TL]    = 1'b1;
        3'd4:    w_strb_dec[C_KS]    = 1'b1;
        3'd5:    w_strb_dec[C_AMSEN] = 1'b1;
        3'd6:    w_strb_dec[C_DT2]   = 1'b1;
        default: w_strb_dec[C_D1L]   = 1'b1;
      endcase
    end
  end

  assign w_op = (addr_q[7:6] != 2'd0) ? addr_q[4:3] : 2'd0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      case (state_q)
        C_IDLE:  if (pend_q) state_d = C_HOLD;
        C_HOLD:  if (cnt_q == C_HOLD_LAST) state_d = C_TAIL;
        C_TAIL:  if (cnt_q == C_BUSY_LAST) state_d = C_IDLE;
        default: state_d = C_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load     = 1'b0;
    w_cnt_inc  = 1'b0;
    w_hold_end = 1'b0;
    w_tail_end = 1'b0;
    if (clk_en) begin
      case (state_q)
        C_IDLE: w_load = pend_q;
        C_HOLD: begin
          w_cnt_inc  = 1'b1;
          w_hold_end = (cnt_q == C_HOLD_LAST);
        end
        C_TAIL: begin
          w_cnt_inc  = 1'b1;
          w_tail_end = (cnt_q == C_BUSY_LAST);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_load)         cnt_d = '0;
    else if (w_cnt_inc) cnt_d = cnt_q + 1'b1;
  end

  // The strobe spans exactly one 32-slot turn so each slot sees the write once.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      d_out_q    <= '0;
      op_q       <= '0;
      ch_q       <= '0;
      strb_q     <= '0;
      busy_q     <= 1'b0;
      glb_wr_q   <= 1'b0;
      glb_addr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (clk_en) glb_wr_q <= 1'b0;
      if (w_load) begin
        d_out_q <= data_q;
        op_q    <= w_op;
        ch_q    <= addr_q[2:0];
        strb_q  <= w_strb_dec;
        busy_q  <= 1'b1;
        if (w_glb) begin
          glb_wr_q   <= 1'b1;
          glb_addr_q <= addr_q;
        end
      end
      if (w_hold_end) strb_q <= '0;
      if (w_tail_end) busy_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign ovr       = ovr_q;
  assign d_out     = d_out_q;
  assign op        = op_q;
  assign ch        = ch_q;
  assign glb_wr    = glb_wr_q;
  assign glb_addr  = glb_addr_q;
  assign up_keyon  = strb_q[C_KEYON];
  assign up_rl     = strb_q[C_RL];
  assign up_kc     = strb_q[C_KC];
  assign up_kf     = strb_q[C_KF];
  assign up_pms    = strb_q[C_PMS];
  assign up_dt1    = strb_q[C_DT1];
  assign up_tl     = strb_q[C_TL];
  assign up_ks     = strb_q[C_KS];
  assign up_amsen  = strb_q[C_AMSEN];
  assign up_dt2    = strb_q[C_DT2];
  assign up_d1l    = strb_q[C_D1L];

endmodule
`default_nettype wire

// File: tb/tb_jt51_regwr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_jt51_regwr                                                   |
// | Purpose  : Directed self-checking bench for jt51_regwr with a scoreboard.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_jt51_regwr;

  logic       clk = 1'b0;
  logic       rst, clk_en, cs_n, wr_n, a0;
  logic [7:0] din;
  logic       busy, ovr, glb_wr;
  logic [7:0] d_out, glb_addr;
  logic [1:0] op;
  logic [2:0] ch;
  logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon;
  logic [10:0] strb;

  always #5 clk = ~clk;

  jt51_regwr #(.BUSY_CYC(64)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
    .busy(busy), .ovr(ovr), .d_out(d_out), .op(op), .ch(ch),
    .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms), .up_dt1(up_dt1),
    .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen), .up_dt2(up_dt2), .up_d1l(up_d1l),
    .up_keyon(up_keyon), .glb_wr(glb_wr), .glb_addr(glb_addr)
  );

  // bit 0 keyon, 1 rl, 2 kc, 3 kf, 4 pms, 5 dt1, 6 tl, 7 ks, 8 amsen, 9 dt2, 10 d1l
  assign strb = {up_d1l, up_dt2, up_amsen, up_ks, up_tl, up_dt1, up_pms, up_kf, up_kc, up_rl, up_keyon};

  typedef struct {
    logic [10:0] strb;
    logic [1:0]  op;
    logic [2:0]  ch;
    logic [7:0]  d;
    logic        glb;
    logic [7:0]  gaddr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic [10:0] s, input logic [1:0] o, input logic [2:0] c,
                              input logic [7:0] d, input logic g, input logic [7:0] ga);
    exp_t e;
    e.strb = s; e.op = o; e.ch = c; e.d = d; e.glb = g; e.gaddr = ga;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d);
    a0 = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
    cyc();
    wr_n = 1'b1; cs_n = 1'b1;
    cyc();
  endtask

  task automatic push_write(input logic [7:0] a, input logic [7:0] d, input exp_t e);
    bus_wr(1'b0, a);
    exp_q.push_back(e);
    bus_wr(1'b1, d);
  endtask

  // Pops the scoreboard entry once busy rises and compares the loaded write.
  task automatic wait_load(input string tag);
    int n = 0;
    while (!busy && n < 10) begin
      cyc();
      n++;
    end
    chk({tag, ":busy_rise"}, 32'(busy), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, ":scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      cur = exp_q.pop_front();
      chk({tag, ":strobe"}, 32'(strb), 32'(cur.strb));
      chk({tag, ":op"}, 32'(op), 32'(cur.op));
      chk({tag, ":ch"}, 32'(ch), 32'(cur.ch));
      chk({tag, ":d_out"}, 32'(d_out), 32'(cur.d));
      chk({tag, ":glb_wr"}, 32'(glb_wr), 32'(cur.glb));
      if (cur.glb) chk({tag, ":glb_addr"}, 32'(glb_addr), 32'(cur.gaddr));
    end
  endtask

  // Counts strobe and busy ticks from the load sample onward; optional overrun
  // injection at busy tick inj and a 20-clk clk_en freeze at tick frz.
  task automatic run_out(input string tag, input int nstrb_exp, input int inj, input int frz);
    int          ns = 0;
    int          nb = 0;
    int          i = 0;
    logic        ovr_seen = 1'b0;
    logic        froze_ok = 1'b1;
    logic [10:0] s0;
    s0 = strb;
    while (busy && i < 300) begin
      nb++;
      if (strb != 11'd0) ns++;
      if (ovr) ovr_seen = 1'b1;
      if (cur.glb && i == 1) chk({tag, ":glb_pulse_end"}, 32'(glb_wr), 32'd0);
      if (inj >= 0) begin
        if (i == inj) begin a0 = 1'b1; din = 8'h11; cs_n = 1'b0; wr_n = 1'b0; end
        if (i == inj + 1) begin
          wr_n = 1'b1; cs_n = 1'b1;
          chk({tag, ":ovr_before"}, 32'(ovr), 32'd0);
        end
        if (i == inj + 2) chk({tag, ":ovr_pulse"}, 32'(ovr), 32'd1);
        if (i == inj + 3) chk({tag, ":ovr_clear"}, 32'(ovr), 32'd0);
      end
      if (i == frz) begin
        clk_en = 1'b0;
        repeat (20) begin
          cyc();
          if (strb != s0 || !busy) froze_ok = 1'b0;
        end
        clk_en = 1'b1;
        chk({tag, ":frozen"}, 32'(froze_ok), 32'd1);
      end
      cyc();
      i++;
    end
    chk({tag, ":strobe_ticks"}, 32'(ns), 32'(nstrb_exp));
    chk({tag, ":busy_ticks"}, 32'(nb), 32'd64);
    chk({tag, ":d_out_kept"}, 32'(d_out), 32'(cur.d));
    chk({tag, ":strobe_off"}, 32'(strb), 32'd0);
    if (inj < 0) chk({tag, ":no_ovr"}, 32'(ovr_seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
    repeat (3) cyc();
    chk("reset:busy", 32'(busy), 32'd0);
    chk("reset:ovr", 32'(ovr), 32'd0);
    chk("reset:strobes", 32'(strb), 32'd0);
    chk("reset:d_out", 32'(d_out), 32'd0);
    chk("reset:op_ch", 32'({op, ch}), 32'd0);
    chk("reset:glb", 32'({glb_wr, glb_addr}), 32'd0);
    rst = 1'b0;
    cyc();

    // 1: KC channel 0
    push_write(8'h28, 8'h4A, mk(11'h004, 2'd0, 3'd0, 8'h4A, 1'b0, 8'h00));
    wait_load("t1");
    run_out("t1", 32, -1, -1);

    // 2: DT1 op 3 ch 3
    push_write(8'h5B, 8'h21, mk(11'h020, 2'd3, 3'd3, 8'h21, 1'b0, 8'h00));
    wait_load("t2");
    run_out("t2", 32, -1, -1);

    // 3: KS op 3 ch 2, data write at busy tick 5 is dropped
    push_write(8'h9A, 8'h6C, mk(11'h080, 2'd3, 3'd2, 8'h6C, 1'b0, 8'h00));
    wait_load("t3");
    run_out("t3", 32, 5, -1);
    repeat (4) cyc();
    chk("t3:no_late_write", 32'(busy), 32'd0);

    // 4: key-on then a global register
    push_write(8'h08, 8'h78, mk(11'h001, 2'd0, 3'd0, 8'h78, 1'b0, 8'h00));
    wait_load("t4a");
    run_out("t4a", 32, -1, -1);
    push_write(8'h0F, 8'h80, mk(11'h000, 2'd0, 3'd7, 8'h80, 1'b1, 8'h0F));
    wait_load("t4b");
    run_out("t4b", 0, -1, -1);

    // 5: reset in the middle of HOLD
    push_write(8'h60, 8'h55, mk(11'h040, 2'd0, 3'd0, 8'h55, 1'b0, 8'h00));
    wait_load("t5");
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    chk("t5:rst_strobes", 32'(strb), 32'd0);
    chk("t5:rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc();
    push_write(8'hFD, 8'h33, mk(11'h400, 2'd3, 3'd5, 8'h33, 1'b0, 8'h00));
    wait_load("t5b");
    run_out("t5b", 32, -1, -1);

    // 6: clk_en held low for 20 clks during HOLD
    push_write(8'h3A, 8'h9C, mk(11'h010, 2'd0, 3'd2, 8'h9C, 1'b0, 8'h00));
    wait_load("t6");
    run_out("t6", 32, -1, 10);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
